// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
//
// Bus arbiter between the SDRAM sequencers and the SDRAM device. After
// power-up init completes, it grants the command bus to exactly one of the
// auto-refresh, write or read sequencers. Priority is refresh > write > read.
// The owner's cmd/ba/addr is muxed onto the SDRAM pins. Every grant passes
// back through ARBIT, so two consecutive grants are separated by at least one
// NOP cycle.
//
// Ports
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   init_end, init_cmd/ba/addr  init sequencer (init_end is a level)
//   aref_req/end, aref_*        auto-refresh sequencer, granted by aref_en
//   wr_req/end, wr_*            write sequencer, granted by wr_en
//   wr_sdram_en, wr_data        write data phase, gated onto the dq pad
//   rd_req/end, rd_*            read sequencer, granted by rd_en
//   sdram_cke                   tied high
//   sdram_cs_n..sdram_we_n      command pins
//   sdram_ba, sdram_addr        bank / address pins
//   sdram_dq_out, sdram_dq_oe   write data to pad and its output enable
//
// State table
//   state | meaning
//   INIT  | power-up init sequencer owns the pins
//   ARBIT | bus idle (NOP), choose the next owner
//   AREF  | auto-refresh sequencer owns the pins
//   WRITE | write sequencer owns the pins and the dq pad
//   READ  | read sequencer owns the pins
// -----------------------------------------------------------------------------
module sdram_arbit #(
  parameter logic [3:0]  NOP       = 4'b0111,
  parameter logic [1:0]  IDLE_BA   = 2'b11,
  parameter logic [11:0] IDLE_ADDR = 12'hfff
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,

  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,

  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [11:0] aref_addr,

  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_data,

  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,

  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,

  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cmd_mux;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
        if (init_end) begin
          state_nxt = ARBIT;
        end
      end
      ARBIT: begin
        if (aref_req) begin
          state_nxt = AREF;
        end else if (wr_req) begin
          state_nxt = WRITE;
        end else if (rd_req) begin
          state_nxt = READ;
        end
      end
      // An owner keeps the bus until its own end pulse; end pulses from the
      // other sequencers and new requests are ignored here.
      AREF: begin
        if (aref_end) begin
          state_nxt = ARBIT;
        end
      end
      WRITE: begin
        if (wr_end) begin
          state_nxt = ARBIT;
        end
      end
      READ: begin
        if (rd_end) begin
          state_nxt = ARBIT;
        end
      end
      // Unused codes: rejoin arbitration only if init has already finished.
      default: begin
        state_nxt = init_end ? ARBIT : INIT;
      end
    endcase
  end

  always_comb begin
    aref_en    = (state == AREF);
    wr_en      = (state == WRITE);
    rd_en      = (state == READ);

    cmd_mux    = NOP;
    sdram_ba   = IDLE_BA;
    sdram_addr = IDLE_ADDR;
    case (state)
      INIT: begin
        cmd_mux    = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        cmd_mux    = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        cmd_mux    = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      READ: begin
        cmd_mux    = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd_mux    = NOP;
        sdram_ba   = IDLE_BA;
        sdram_addr = IDLE_ADDR;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;

  assign sdram_cke = 1'b1;

  // The dq pad is only ever driven by the write sequencer while it owns the bus.
  assign sdram_dq_oe  = (state == WRITE) ? wr_sdram_en : 1'b0;
  assign sdram_dq_out = (state == WRITE) ? wr_data : 16'h0000;

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_ARBIT = 3'd1;
  localparam logic [2:0] S_AREF  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [11:0] init_addr;
  logic        aref_req, aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [11:0] aref_addr;
  logic        wr_req, wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [11:0] wr_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_data;
  logic        rd_req, rd_end;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [11:0] rd_addr;
  logic        aref_en, wr_en, rd_en;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  always #5 sys_clk = ~sys_clk;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
    .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  typedef struct {
    logic        ie, arq, aend, wrq, wend, rrq, rend, wen;
    logic [15:0] wdata;
    logic [2:0]  est;
    logic        eoe;
    logic [15:0] edq;
  } vec_t;

  typedef struct {
    logic [2:0]  est;
    logic        eoe;
    logic [15:0] edq;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[27];

  function automatic vec_t mk(logic ie, logic arq, logic aend, logic wrq, logic wend,
                              logic rrq, logic rend, logic wen, logic [15:0] wdata,
                              logic [2:0] est, logic eoe, logic [15:0] edq);
    vec_t v;
    v.ie = ie; v.arq = arq; v.aend = aend; v.wrq = wrq; v.wend = wend;
    v.rrq = rrq; v.rend = rend; v.wen = wen; v.wdata = wdata;
    v.est = est; v.eoe = eoe; v.edq = edq;
    return v;
  endfunction

  task automatic chk(string tag, string what, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, expv);
    end
  endtask

  task automatic randomize_cmds();
    init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = 12'($urandom);
    aref_cmd = 4'($urandom); aref_ba = 2'($urandom); aref_addr = 12'($urandom);
    wr_cmd   = 4'($urandom); wr_ba   = 2'($urandom); wr_addr   = 12'($urandom);
    rd_cmd   = 4'($urandom); rd_ba   = 2'($urandom); rd_addr   = 12'($urandom);
  endtask

  task automatic drive(vec_t v);
    init_end = v.ie; aref_req = v.arq; aref_end = v.aend;
    wr_req = v.wrq; wr_end = v.wend; rd_req = v.rrq; rd_end = v.rend;
    wr_sdram_en = v.wen; wr_data = v.wdata;
    randomize_cmds();
  endtask

  task automatic push_exp(logic [2:0] est, logic eoe, logic [15:0] edq, string tag);
    exp_t e;
    e.est = est; e.eoe = eoe; e.edq = edq; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic compare_one();
    exp_t        e;
    logic [17:0] pins_exp;
    logic [2:0]  g_exp;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    g_exp = {e.est == S_READ, e.est == S_WRITE, e.est == S_AREF};
    case (e.est)
      S_INIT:  pins_exp = {init_cmd, init_ba, init_addr};
      S_AREF:  pins_exp = {aref_cmd, aref_ba, aref_addr};
      S_WRITE: pins_exp = {wr_cmd, wr_ba, wr_addr};
      S_READ:  pins_exp = {rd_cmd, rd_ba, rd_addr};
      default: pins_exp = {4'b0111, 2'b11, 12'hfff};
    endcase
    chk(e.tag, "grants{rd,wr,aref}", 32'({rd_en, wr_en, aref_en}), 32'(g_exp));
    chk(e.tag, "pins{cmd,ba,addr}",
        32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr}),
        32'(pins_exp));
    chk(e.tag, "cke", 32'(sdram_cke), 32'(1'b1));
    chk(e.tag, "dq_oe", 32'(sdram_dq_oe), 32'(e.eoe));
    chk(e.tag, "dq_out", 32'(sdram_dq_out), 32'(e.edq));
  endtask

  task automatic step(vec_t v, string tag);
    @(posedge sys_clk);
    #1;
    drive(v);
    push_exp(v.est, v.eoe, v.edq, tag);
    @(negedge sys_clk);
    compare_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ie arq aend wrq wend rrq rend wen  wdata     state    oe  dq
    tbl[0]  = mk(1,0,0,0,0,0,0,0, 16'h0000, S_INIT,  0, 16'h0000);
    tbl[1]  = mk(1,0,0,0,0,0,0,0, 16'h0000, S_ARBIT, 0, 16'h0000);
    tbl[2]  = mk(1,1,0,0,0,0,0,0, 16'h0000, S_ARBIT, 0, 16'h0000);
    tbl[3]  = mk(1,1,0,0,0,0,0,0, 16'h0000, S_AREF,  0, 16'h0000);
    tbl[4]  = mk(1,0,1,0,0,0,0,0, 16'h0000, S_AREF,  0, 16'h0000);
    tbl[5]  = mk(1,0,0,0,0,0,0,0, 16'h0000, S_ARBIT, 0, 16'h0000);
    tbl[6]  = mk(1,1,0,1,0,1,0,0, 16'h0000, S_ARBIT, 0, 16'h0000);
    tbl[7]  = mk(1,0,0,1,0,1,0,0, 16'h0000, S_AREF,  0, 16'h0000);
    tbl[8]  = mk(1,0,1,1,0,1,0,0, 16'h0000, S_AREF,  0, 16'h0000);
    tbl[9]  = mk(1,0,0,1,0,1,0,1, 16'h1111, S_ARBIT, 0, 16'h0000);
    tbl[10] = mk(1,1,0,0,0,1,0,1, 16'hA5A5, S_WRITE, 1, 16'hA5A5);
    tbl[11] = mk(1,1,0,0,0,1,0,0, 16'h1234, S_WRITE, 0, 16'h1234);
    tbl[12] = mk(1,1,0,0,1,1,0,1, 16'h5A5A, S_WRITE, 1, 16'h5A5A);
    tbl[13] = mk(1,1,0,0,0,1,0,1, 16'hFFFF, S_ARBIT, 0, 16'h0000);
    tbl[14] = mk(1,0,0,0,0,1,0,0, 16'h0000, S_AREF,  0, 16'h0000);
    tbl[15] = mk(1,0,0,0,0,1,1,0, 16'h0000, S_AREF,  0, 16'h0000);
    tbl[16] = mk(1,0,1,0,0,1,0,0, 16'h0000, S_AREF,  0, 16'h0000);
    tbl[17] = mk(1,0,0,0,0,1,0,0, 16'h0000, S_ARBIT, 0, 16'h0000);
    tbl[18] = mk(1,0,0,0,0,0,0,1, 16'hA5A5, S_READ,  0, 16'h0000);
    tbl[19] = mk(1,0,1,0,1,0,0,1, 16'hA5A5, S_READ,  0, 16'h0000);
    tbl[20] = mk(1,0,0,0,0,0,1,0, 16'h0000, S_READ,  0, 16'h0000);
    tbl[21] = mk(1,0,0,0,0,0,0,0, 16'h0000, S_ARBIT, 0, 16'h0000);
    tbl[22] = mk(1,0,0,1,0,1,0,0, 16'h0000, S_ARBIT, 0, 16'h0000);
    tbl[23] = mk(1,0,0,0,0,1,0,0, 16'h0000, S_WRITE, 0, 16'h0000);
    tbl[24] = mk(1,0,0,0,1,1,0,0, 16'h0000, S_WRITE, 0, 16'h0000);
    tbl[25] = mk(1,0,0,0,0,1,0,0, 16'h0000, S_ARBIT, 0, 16'h0000);
    tbl[26] = mk(1,0,0,0,0,0,0,0, 16'h0000, S_READ,  0, 16'h0000);

    // Reset values: grants low and pins follow init_* even with init_end and
    // write data enable already high.
    sys_rst_n = 1'b0;
    drive(mk(1,0,0,0,0,0,0,1, 16'hBEEF, S_INIT, 0, 16'h0000));
    #23;
    push_exp(S_INIT, 1'b0, 16'h0000, "reset");
    compare_one();
    @(negedge sys_clk);
    init_end = 1'b0;
    sys_rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      step(mk(0,0,0,0,0,0,0,0, 16'h0000, S_INIT, 0, 16'h0000), $sformatf("init_hold%0d", i));
    end

    for (int i = 0; i < 27; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while the write sequencer owns the bus.
    step(mk(1,0,0,0,0,0,1,0, 16'h0000, S_READ,  0, 16'h0000), "rst_seq0");
    step(mk(1,0,0,1,0,0,0,0, 16'h0000, S_ARBIT, 0, 16'h0000), "rst_seq1");
    step(mk(1,0,0,0,0,0,0,1, 16'hBEEF, S_WRITE, 1, 16'hBEEF), "rst_seq2");
    @(posedge sys_clk);
    #2;
    init_end = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    push_exp(S_INIT, 1'b0, 16'h0000, "rst_midwrite");
    compare_one();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(mk(0,0,0,1,0,0,0,1, 16'hBEEF, S_INIT,  0, 16'h0000), "rst_seq3");
    step(mk(1,0,0,1,0,0,0,1, 16'hBEEF, S_INIT,  0, 16'h0000), "rst_seq4");
    step(mk(1,0,0,1,0,0,0,0, 16'h0000, S_ARBIT, 0, 16'h0000), "rst_seq5");
    step(mk(1,0,0,0,0,0,0,1, 16'h0F0F, S_WRITE, 1, 16'h0F0F), "rst_seq6");

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
